rx_serial_bcd_7o1: RTL and testbench

- Receive end of the 3-digit BCD serial link.
- Deserialises 7O1 asynchronous characters: 1 start bit, 7 data bits LSB first, odd parity, 1 stop bit.
- Checks the message format: three ASCII digits '0'..'9' followed by '#' (0x23).
- Presents the 12-bit BCD result with a one-cycle pronto pulse. Sits between the serial input pin and downstream display/compare logic.

---
 rtl/rx_serial_bcd_7o1.sv | 171 +++++++++++++++++
 tb/tb_rx_serial_bcd_7o1.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_bcd_7o1.sv
// rtl/rx_serial_bcd_7o1.sv - 7O1 serial receiver that assembles "ddd#" messages into 12-bit BCD.
// Optional 2-FF input synchroniser: define RX_SINCRONIZADOR_EN.
module rx_serial_bcd_7o1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] dados,
    output logic        pronto,
    output logic        erro_paridade,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } estado_t;

    logic rx;

`ifdef RX_SINCRONIZADOR_EN
    logic [1:0] sync_q;
    always_ff @(posedge clock) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], entrada_serial};
    end
    assign rx = sync_q[1];
`else
    assign rx = entrada_serial;
`endif

    estado_t       estado_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    nbit_q;
    logic [6:0]    shift_q;
    logic          paridade_q;
    logic          parada_q;
    logic          char_rdy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            tick_q     <= '0;
            nbit_q     <= '0;
            shift_q    <= '0;
            paridade_q <= 1'b0;
            parada_q   <= 1'b0;
            char_rdy_q <= 1'b0;
        end else begin
            char_rdy_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    tick_q <= '0;
                    if (!rx) estado_q <= INICIO;
                end
                INICIO: begin
                    if (tick_q == TICK_HALF) begin
                        tick_q   <= '0;
                        nbit_q   <= '0;
                        estado_q <= rx ? OCIOSO : DADOS;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DADOS: begin
                    if (tick_q == TICK_FULL) begin
                        tick_q  <= '0;
                        shift_q <= {rx, shift_q[6:1]};
                        nbit_q  <= nbit_q + 3'd1;
                        if (nbit_q == 3'd6) estado_q <= PARIDADE;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                PARIDADE: begin
                    if (tick_q == TICK_FULL) begin
                        tick_q     <= '0;
                        paridade_q <= rx;
                        estado_q   <= PARADA;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                PARADA: begin
                    if (tick_q == TICK_FULL) begin
                        tick_q     <= '0;
                        parada_q   <= rx;
                        char_rdy_q <= 1'b1;
                        estado_q   <= OCIOSO;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] hold_q, hold_d;
    logic [11:0] dados_q, dados_d;
    logic        pronto_q, pronto_d;
    logic        epar_q, epar_d;
    logic        efmt_q, efmt_d;

    // Digits shift into hold_q so the first received ends up in [11:8].
    always_comb begin
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        dados_d  = dados_q;
        pronto_d = 1'b0;
        epar_d   = 1'b0;
        efmt_d   = 1'b0;
        if (char_rdy_q) begin
            if (^{shift_q, paridade_q} == 1'b0) begin
                epar_d = 1'b1;
                cnt_d  = 2'd0;
            end else if (!parada_q) begin
                efmt_d = 1'b1;
                cnt_d  = 2'd0;
            end else if (shift_q >= 7'h30 && shift_q <= 7'h39) begin
                if (cnt_q != 2'd3) begin
                    hold_d = {hold_q[7:0], shift_q[3:0]};
                    cnt_d  = cnt_q + 2'd1;
                end else begin
                    efmt_d = 1'b1;
                    cnt_d  = 2'd0;
                end
            end else if (shift_q == 7'h23 && cnt_q == 2'd3) begin
                dados_d  = hold_q;
                pronto_d = 1'b1;
                cnt_d    = 2'd0;
            end else begin
                efmt_d = 1'b1;
                cnt_d  = 2'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= 2'd0;
            hold_q   <= 12'h000;
            dados_q  <= 12'h000;
            pronto_q <= 1'b0;
            epar_q   <= 1'b0;
            efmt_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            dados_q  <= dados_d;
            pronto_q <= pronto_d;
            epar_q   <= epar_d;
            efmt_q   <= efmt_d;
        end
    end

    assign dados         = dados_q;
    assign pronto        = pronto_q;
    assign erro_paridade = epar_q;
    assign erro_formato  = efmt_q;
    assign db_estado     = {estado_q, cnt_q != 2'd0};
endmodule

// File: tb/tb_rx_serial_bcd_7o1.sv
// tb/tb_rx_serial_bcd_7o1.sv - randomized and directed bench for rx_serial_bcd_7o1 against a message-level model.
module tb_rx_serial_bcd_7o1;
    localparam int C = 8;
    localparam int H = C / 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [11:0] dados;
    logic        pronto, erro_paridade, erro_formato;
    logic [3:0]  db_estado;

    rx_serial_bcd_7o1 #(.CLKS_PER_BIT(C)) dut (
        .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
        .dados(dados), .pronto(pronto), .erro_paridade(erro_paridade),
        .erro_formato(erro_formato), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    logic rst_edge = 1'b1;
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    typedef struct {
        int         t;
        logic [6:0] ch;
        bit         par_ok;
        bit         stop_ok;
    } ev_t;
    ev_t evq[$];

    int          checks = 0;
    int          errors = 0;
    int          m_cnt = 0;
    logic [11:0] m_dados = 12'h000;
    logic [3:0]  m_dig [3];
    int          d_pr = 0, d_ep = 0, d_ef = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Message-level model: each received character resolves at a known cycle.
    always @(negedge clock) begin
        bit  e_pr, e_ep, e_ef;
        ev_t ev;
        e_pr = 0; e_ep = 0; e_ef = 0;
        if (rst_edge) begin
            m_cnt = 0;
            m_dados = 12'h000;
            evq.delete();
        end else if (evq.size() > 0 && evq[0].t <= cyc) begin
            ev = evq.pop_front();
            chk("schedule", ev.t, cyc);
            if (!ev.par_ok) begin
                e_ep = 1; m_cnt = 0;
            end else if (!ev.stop_ok) begin
                e_ef = 1; m_cnt = 0;
            end else if (ev.ch >= 7'h30 && ev.ch <= 7'h39) begin
                if (m_cnt < 3) begin
                    m_dig[m_cnt] = ev.ch[3:0];
                    m_cnt++;
                end else begin
                    e_ef = 1; m_cnt = 0;
                end
            end else if (ev.ch == 7'h23 && m_cnt == 3) begin
                m_dados = {m_dig[0], m_dig[1], m_dig[2]};
                e_pr = 1; m_cnt = 0;
            end else begin
                e_ef = 1; m_cnt = 0;
            end
        end
        chk("pronto", int'(pronto), int'(e_pr));
        chk("erro_paridade", int'(erro_paridade), int'(e_ep));
        chk("erro_formato", int'(erro_formato), int'(e_ef));
        chk("dados", int'(dados), int'(m_dados));
        chk("cnt_nz", int'(db_estado[0]), (m_cnt != 0) ? 1 : 0);
        if (pronto === 1'b1) d_pr++;
        if (erro_paridade === 1'b1) d_ep++;
        if (erro_formato === 1'b1) d_ef++;
    end

    task automatic send_char(input logic [6:0] ch, input bit bad_par, input bit bad_stop);
        logic       p;
        logic [9:0] frame;
        ev_t        e;
        p = (~^ch) ^ bad_par;
        frame = {~bad_stop, p, ch, 1'b0};
        e.t = cyc + 2 + H + 9 * C;
        e.ch = ch;
        e.par_ok = (^{ch, p}) == 1'b1;
        e.stop_ok = !bad_stop;
        evq.push_back(e);
        for (int i = 0; i < 10; i++) begin
            entrada_serial = frame[i];
            repeat (C) @(negedge clock);
        end
        if (bad_stop) begin
            entrada_serial = 1'b1;
            repeat (2 * C) @(negedge clock);
        end
    endtask

    task automatic send_str(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b[6:0], 1'b0, 1'b0);
        end
    endtask

    task automatic clr_counts();
        d_pr = 0; d_ep = 0; d_ef = 0;
    endtask

    initial begin
        logic [6:0] rc;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        clr_counts();
        send_str("123#");
        repeat (2 * C) @(negedge clock);
        chk("t1_dados", int'(dados), 'h123);
        chk("t1_pronto_count", d_pr, 1);
        chk("t1_err_count", d_ep + d_ef, 0);

        clr_counts();
        send_str("907#");
        send_char(7'h34, 1'b1, 1'b0);
        chk("t2_dados_hold", int'(dados), 'h907);
        send_str("560#");
        repeat (2 * C) @(negedge clock);
        chk("t2_dados", int'(dados), 'h560);
        chk("t2_epar_count", d_ep, 1);
        chk("t2_pronto_count", d_pr, 2);

        clr_counts();
        send_str("12#");
        send_str("345#");
        repeat (2 * C) @(negedge clock);
        chk("t3_dados", int'(dados), 'h345);
        chk("t3_efmt_count", d_ef, 1);
        chk("t3_pronto_count", d_pr, 1);

        clr_counts();
        send_char(7'h35, 1'b0, 1'b1);
        send_str("678#");
        repeat (2 * C) @(negedge clock);
        chk("t4_dados", int'(dados), 'h678);
        chk("t4_efmt_count", d_ef, 1);

        clr_counts();
        entrada_serial = 1'b0;
        for (int i = 0; i < 3 * C; i++) begin
            if (i == 3) entrada_serial = 1'b1;
            chk("glitch_state", (db_estado[3:1] <= 3'd1) ? 1 : 0, 1);
            @(negedge clock);
        end
        chk("glitch_flags", d_pr + d_ep + d_ef, 0);
        send_char(7'h39, 1'b0, 1'b0);
        entrada_serial = 1'b0;
        repeat (C) @(negedge clock);
        entrada_serial = 1'b0;
        repeat (3 * C) @(negedge clock);
        reset = 1'b1;
        entrada_serial = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_dados", int'(dados), 0);
        chk("rst_db_estado", int'(db_estado), 0);
        repeat (2 * C) @(negedge clock);
        send_str("111#");
        repeat (2 * C) @(negedge clock);
        chk("t5_dados", int'(dados), 'h111);

        clr_counts();
        send_str("1234#");
        repeat (2 * C) @(negedge clock);
        chk("t6_efmt_count", d_ef, 2);
        chk("t6_pronto_count", d_pr, 0);
        chk("t6_dados", int'(dados), 'h111);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                6, 7:    rc = 7'h23;
                8:       rc = 7'($urandom_range(0, 127));
                default: rc = 7'(7'h30 + $urandom_range(0, 9));
            endcase
            send_char(rc, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2 * C)) @(negedge clock);
        end
        repeat (3 * C) @(negedge clock);
        chk("queue_drained", evq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
